// File: rtl/config_stream_driver_pkg.sv
// Shared definitions for the fabric configuration chain driver: FSM encoding
// and the words-per-chain sizing helper also used by host firmware headers.
package config_stream_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_SET   = 2'd3
    } state_t;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_CHAIN_LEN  = 1024;
    localparam int DEF_SET_CYCLES = 2;

    // Host words needed to fill the chain; the last one may be partially used.
    function automatic int words_per_chain(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    localparam int DEF_WORDS_PER_CHAIN = words_per_chain(DEF_CHAIN_LEN, DEF_WORD_W);

endpackage

// File: rtl/config_word_serializer.sv
// LSB-first word serializer. Bit 0 of a word leaves on the load edge itself, so
// the register keeps only the bits still to be sent after the current one.
module config_word_serializer
    import config_stream_driver_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    localparam int WW    = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic [WW-1:0]     i_nbits,
    input  logic              i_shift,
    output logic              o_bit,
    output logic              o_last_bit
);

    logic [WORD_W-1:0] r_shreg;
    logic [WW-1:0]     r_word_bits;

    // Shift register and count of word bits still waiting behind the current one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg     <= '0;
            r_word_bits <= '0;
        end else if (i_load) begin
            r_shreg     <= {1'b0, i_word[WORD_W-1:1]};
            r_word_bits <= i_nbits - WW'(1);
        end else if (i_shift) begin
            r_shreg     <= {1'b0, r_shreg[WORD_W-1:1]};
            r_word_bits <= r_word_bits - WW'(1);
        end
    end

    assign o_bit      = r_shreg[0];
    assign o_last_bit = (r_word_bits == '0);

endmodule

// File: rtl/config_stream_driver.sv
// Head-end driver of the tile configuration chain: fetches host words, shifts
// exactly CHAIN_LEN qualified bits into the first tile, then pulses the chain set.
module config_stream_driver
    import config_stream_driver_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int SET_CYCLES = DEF_SET_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cen,
    output logic              shift_out,
    output logic              set_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);
    localparam int SW = $clog2(SET_CYCLES + 1);

    state_t        r_state;
    logic [CW-1:0] r_bits_left;
    logic [SW-1:0] r_set_cnt;
    logic          r_cen;
    logic          r_shift_out;
    logic          r_set_out;
    logic          r_busy;
    logic          r_done;

    state_t        w_state_nxt;
    logic [CW-1:0] w_bits_left_nxt;
    logic [SW-1:0] w_set_cnt_nxt;
    logic          w_cen_nxt;
    logic          w_shift_out_nxt;
    logic          w_set_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_load;
    logic          w_shift;
    logic          w_bit;
    logic          w_last_bit;
    logic [WW-1:0] w_nbits;

    // The final word is clipped to the chain bits still outstanding.
    assign w_nbits = (32'(r_bits_left) < WORD_W) ? WW'(r_bits_left) : WW'(WORD_W);

    config_word_serializer #(.WORD_W(WORD_W)) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_word     (word_in),
        .i_nbits    (w_nbits),
        .i_shift    (w_shift),
        .o_bit      (w_bit),
        .o_last_bit (w_last_bit)
    );

    // Next-state and next-output logic; cen is high for every SHIFT-state cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_bits_left_nxt = r_bits_left;
        w_set_cnt_nxt   = r_set_cnt;
        w_cen_nxt       = 1'b0;
        w_shift_out_nxt = r_shift_out;
        w_set_nxt       = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = ST_FETCH;
                    w_bits_left_nxt = CW'(CHAIN_LEN);
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (word_valid) begin
                    w_load          = 1'b1;
                    w_cen_nxt       = 1'b1;
                    w_shift_out_nxt = word_in[0];
                    w_bits_left_nxt = r_bits_left - CW'(1);
                    w_state_nxt     = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_SHIFT: begin
                if (!w_last_bit) begin
                    w_shift         = 1'b1;
                    w_cen_nxt       = 1'b1;
                    w_shift_out_nxt = w_bit;
                    w_bits_left_nxt = r_bits_left - CW'(1);
                end else if (r_bits_left == '0) begin
                    w_state_nxt   = ST_SET;
                    w_set_nxt     = 1'b1;
                    w_set_cnt_nxt = SW'(SET_CYCLES - 1);
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_SET: begin
                if (r_set_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_set_nxt     = 1'b1;
                    w_set_cnt_nxt = r_set_cnt - SW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_bits_left <= '0;
            r_set_cnt   <= '0;
            r_cen       <= 1'b0;
            r_shift_out <= 1'b0;
            r_set_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bits_left <= w_bits_left_nxt;
            r_set_cnt   <= w_set_cnt_nxt;
            r_cen       <= w_cen_nxt;
            r_shift_out <= w_shift_out_nxt;
            r_set_out   <= w_set_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign word_ready = (r_state == ST_FETCH);
    assign cen        = r_cen;
    assign shift_out  = r_shift_out;
    assign set_out    = r_set_out;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_config_stream_driver.sv
// Bench for config_stream_driver: a 40-bit and a 64-bit chain instance share
// stimulus, and the captured serial stream is compared with a word-level model.
module tb_config_stream_driver;

    localparam int SET_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        word_valid;
    logic        sel;
    logic [31:0] word_in;

    logic start_a, valid_a, ready_a, cen_a, so_a, set_a, busy_a, done_a;
    logic start_b, valid_b, ready_b, cen_b, so_b, set_b, busy_b, done_b;
    logic word_ready, cen, shift_out, set_out, busy, done;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign valid_a = word_valid & ~sel;
    assign start_b = start & sel;
    assign valid_b = word_valid & sel;

    assign word_ready = sel ? ready_b : ready_a;
    assign cen        = sel ? cen_b   : cen_a;
    assign shift_out  = sel ? so_b    : so_a;
    assign set_out    = sel ? set_b   : set_a;
    assign busy       = sel ? busy_b  : busy_a;
    assign done       = sel ? done_b  : done_a;

    config_stream_driver #(.WORD_W(32), .CHAIN_LEN(40), .SET_CYCLES(SET_CYC)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .word_in(word_in), .word_valid(valid_a),
        .word_ready(ready_a), .cen(cen_a), .shift_out(so_a), .set_out(set_a),
        .busy(busy_a), .done(done_a)
    );

    config_stream_driver #(.WORD_W(32), .CHAIN_LEN(64), .SET_CYCLES(SET_CYC)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .word_in(word_in), .word_valid(valid_b),
        .word_ready(ready_b), .cen(cen_b), .shift_out(so_b), .set_out(set_b),
        .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Observation of the selected instance, sampled on the falling edge.
    logic        mon_clr = 1'b1;
    logic [63:0] cap_vec;
    int          cap_n, set_cnt, overlap, done_rise, fetch_rise, cyc, last_cen, first_set;
    logic        prev_done, prev_wr;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            cap_vec    <= '0;
            cap_n      <= 0;
            set_cnt    <= 0;
            overlap    <= 0;
            done_rise  <= 0;
            fetch_rise <= 0;
            last_cen   <= -1;
            first_set  <= -1;
            prev_done  <= done;
            prev_wr    <= word_ready;
        end else begin
            if (cen) begin
                if (cap_n < 64) cap_vec[cap_n] <= shift_out;
                cap_n    <= cap_n + 1;
                last_cen <= cyc;
            end
            if (set_out) begin
                set_cnt <= set_cnt + 1;
                if (first_set < 0) first_set <= cyc;
            end
            if (cen && set_out) overlap <= overlap + 1;
            if (done && !prev_done) done_rise <= done_rise + 1;
            if (word_ready && !prev_wr) fetch_rise <= fetch_rise + 1;
            prev_done <= done;
            prev_wr   <= word_ready;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // Chain contents: words concatenated LSB first, cut off at chain_len bits.
    function automatic logic [63:0] model(input int chain, input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] full;
        logic [63:0] mask;
        full = {w1, w0};
        mask = (chain >= 64) ? '1 : ((64'd1 << chain) - 64'd1);
        return full & mask;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cen"},   64'(cen),        64'd0);
        check({tag, "_so"},    64'(shift_out),  64'd0);
        check({tag, "_set"},   64'(set_out),    64'd0);
        check({tag, "_ready"}, 64'(word_ready), 64'd0);
        check({tag, "_busy"},  64'(busy),       64'd0);
        check({tag, "_done"},  64'(done),       64'd0);
    endtask

    task automatic run_load(input string tag, input int chain, input logic [31:0] w0,
                            input logic [31:0] w1, input int d0, input int d1, input bit ign);
        logic [31:0] ws[2];
        int          dl[2];
        ws[0] = w0; ws[1] = w1; dl[0] = d0; dl[1] = d1;
        clear_monitor();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_on"},  64'(busy), 64'd1);
        check({tag, "_done_clr"}, 64'(done), 64'd0);
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 100 && !word_ready; t++) tick();
            check({tag, "_ready_wait"}, 64'(word_ready), 64'd1);
            for (int d = 0; d < dl[k]; d++) begin
                check({tag, "_bp_ready"}, 64'(word_ready), 64'd1);
                check({tag, "_bp_cen"},   64'(cen),        64'd0);
                tick();
            end
            word_valid = 1'b1;
            word_in    = ws[k];
            tick();
            word_valid = 1'b0;
            word_in    = $urandom;
            if (ign && k == 0) begin
                tick(); tick(); tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        if (ign) begin
            for (int t = 0; t < 100 && !set_out; t++) tick();
            check({tag, "_set_wait"}, 64'(set_out), 64'd1);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int t = 0; t < 200 && !done; t++) tick();
        check({tag, "_done_wait"}, 64'(done), 64'd1);
        tick(); tick(); tick();
        check({tag, "_stream"},    cap_vec,          model(chain, w0, w1));
        check({tag, "_cen_count"}, 64'(cap_n),       64'(chain));
        check({tag, "_set_len"},   64'(set_cnt),     64'(SET_CYC));
        check({tag, "_overlap"},   64'(overlap),     64'd0);
        check({tag, "_set_gap"},   64'(first_set - last_cen), 64'd1);
        check({tag, "_fetches"},   64'(fetch_rise),  64'd2);
        check({tag, "_done_once"}, 64'(done_rise),   64'd1);
        check({tag, "_done_end"},  64'(done),        64'd1);
        check({tag, "_busy_end"},  64'(busy),        64'd0);
        check({tag, "_idle"},      64'(word_ready),  64'd0);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        word_in    = '0;
        sel        = 1'b0;
        cyc        = 0;
        tick(); tick(); tick();
        check_idle_outputs("rst_a");
        sel = 1'b1;
        #1;
        check_idle_outputs("rst_b");
        sel = 1'b0;
        rst = 1'b1;
        tick(); tick();

        run_load("basic", 40, 32'hA5A5_A5A5, 32'h0000_00FF, 0, 0, 1'b0);
        check("basic_pattern", cap_vec, 64'h0000_00FF_A5A5_A5A5);

        run_load("trunc", 40, 32'hA5A5_A5A5, 32'hFFFF_FF00, 0, 0, 1'b0);
        check("trunc_pattern", cap_vec, 64'h0000_0000_A5A5_A5A5);

        run_load("bkpr", 40, $urandom, $urandom, 10, 10, 1'b0);
        run_load("ign", 40, $urandom, $urandom, 0, 2, 1'b1);

        // Reset in the middle of the first word.
        clear_monitor();
        start = 1'b1;
        tick();
        start      = 1'b0;
        word_valid = 1'b1;
        word_in    = $urandom;
        tick();
        word_valid = 1'b0;
        for (int t = 0; t < 100 && cap_n < 20; t++) tick();
        check("mid_bits", 64'(cap_n), 64'd20);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        tick(); tick();
        rst = 1'b1;
        for (int t = 0; t < 10; t++) tick();
        check("mid_no_set",  64'(set_cnt), 64'd0);
        check("mid_no_busy", 64'(busy),    64'd0);
        run_load("after_rst", 40, $urandom, $urandom, 1, 0, 1'b0);

        sel = 1'b1;
        run_load("exact", 64, $urandom, $urandom, 0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            run_load("rand", sel ? 64 : 40, $urandom, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
